// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed display bus, captures each digit once its
// select/segment pair has been stable, and reports whole frames. Define SEG_ERR_CNT_EN to add errCnt.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic [7:0]  segIn,
   input  logic [7:0]  digIn,
   output logic [31:0] hexOut,
   output logic [7:0]  dpOut,
   output logic [7:0]  digValid,
   output logic        frameValid,
   output logic        errPulse
`ifdef SEG_ERR_CNT_EN
   ,
   output logic [7:0]  errCnt
`endif
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   state_t      r_state, w_nextState;
   logic [7:0]  r_cnt, w_nextCnt;
   logic [7:0]  r_seg, r_dig, r_segPrev, r_digPrev;
   logic        w_same, w_noSel, w_multiSel, w_eval;
   logic        w_capture, w_selErr, w_legal, w_err;
   logic [2:0]  w_digIdx;
   logic [4:0]  w_decode;
   logic [7:0]  w_newValid;

   // Returns {legal, value}; anything outside the hex glyph set is illegal.
   function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
      case (seg)
         7'h3F:   decodeSeg = {1'b1, 4'h0};
         7'h06:   decodeSeg = {1'b1, 4'h1};
         7'h5B:   decodeSeg = {1'b1, 4'h2};
         7'h4F:   decodeSeg = {1'b1, 4'h3};
         7'h66:   decodeSeg = {1'b1, 4'h4};
         7'h6D:   decodeSeg = {1'b1, 4'h5};
         7'h7D:   decodeSeg = {1'b1, 4'h6};
         7'h07:   decodeSeg = {1'b1, 4'h7};
         7'h7F:   decodeSeg = {1'b1, 4'h8};
         7'h6F:   decodeSeg = {1'b1, 4'h9};
         7'h77:   decodeSeg = {1'b1, 4'hA};
         7'h7C:   decodeSeg = {1'b1, 4'hB};
         7'h39:   decodeSeg = {1'b1, 4'hC};
         7'h5E:   decodeSeg = {1'b1, 4'hD};
         7'h79:   decodeSeg = {1'b1, 4'hE};
         7'h71:   decodeSeg = {1'b1, 4'hF};
         default: decodeSeg = {1'b0, 4'h0};
      endcase
   endfunction

   always_comb begin
      w_digIdx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!r_dig[i]) w_digIdx = 3'(i);
      end
   end

   assign w_same     = (r_seg == r_segPrev) && (r_dig == r_digPrev);
   assign w_noSel    = (r_dig == 8'hFF);
   assign w_multiSel = ($countones(~r_dig) > 1);
   assign w_decode   = decodeSeg(r_seg[6:0]);
   assign w_legal    = w_decode[4];
   assign w_err      = w_selErr || (w_capture && !w_legal);
   assign w_newValid = digValid | (8'h01 << w_digIdx);

   // Next state: count while the pair holds, otherwise re-evaluate the select as from IDLE.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_capture   = 1'b0;
      w_selErr    = 1'b0;
      w_eval      = 1'b0;
      case (r_state)
         SETTLE: begin
            if (w_same) begin
               if (r_cnt < STABLE) w_nextCnt = r_cnt + 8'd1;
               if (w_nextCnt == STABLE) begin
                  w_capture   = 1'b1;
                  w_nextState = HOLD;
               end
            end else begin
               w_eval = 1'b1;
            end
         end
         HOLD:    w_eval = !w_same;
         default: w_eval = 1'b1;
      endcase
      if (w_eval) begin
         if (w_noSel) begin
            w_nextState = IDLE;
            w_nextCnt   = 8'd0;
         end else if (w_multiSel) begin
            // A held multi-select flags once on entry, not every cycle it persists.
            w_nextState = IDLE;
            w_nextCnt   = 8'd0;
            w_selErr    = (r_state != IDLE) || !w_same;
         end else begin
            w_nextCnt = 8'd1;
            if (STABLE == 8'd1) begin
               w_capture   = 1'b1;
               w_nextState = HOLD;
            end else begin
               w_nextState = SETTLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= IDLE;
         r_cnt      <= 8'd0;
         r_seg      <= 8'h00;
         r_dig      <= 8'hFF;
         r_segPrev  <= 8'h00;
         r_digPrev  <= 8'hFF;
         hexOut     <= 32'd0;
         dpOut      <= 8'd0;
         digValid   <= 8'd0;
         frameValid <= 1'b0;
         errPulse   <= 1'b0;
      end else begin
         r_seg      <= segIn;
         r_dig      <= digIn;
         r_segPrev  <= r_seg;
         r_digPrev  <= r_dig;
         r_state    <= w_nextState;
         r_cnt      <= w_nextCnt;
         errPulse   <= w_err;
         frameValid <= 1'b0;
         if (w_capture && w_legal) begin
            hexOut[{w_digIdx, 2'b00} +: 4] <= w_decode[3:0];
            dpOut[w_digIdx]                <= r_seg[7];
            // The capture completing a frame announces it and starts the next frame empty.
            if (w_newValid == 8'hFF) begin
               digValid   <= 8'd0;
               frameValid <= 1'b1;
            end else begin
               digValid   <= w_newValid;
            end
         end
      end
   end

`ifdef SEG_ERR_CNT_EN
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         errCnt <= 8'd0;
      end else if (w_err && (errCnt != 8'hFF)) begin
         errCnt <= errCnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed table-driven bench for seg_scan_decoder with STABLE_CYCLES at its default of 4.
module tb_seg_scan_decoder;

   logic        clk;
   logic        nRst;
   logic [7:0]  segIn;
   logic [7:0]  digIn;
   logic [31:0] hexOut;
   logic [7:0]  dpOut;
   logic [7:0]  digValid;
   logic        frameValid;
   logic        errPulse;
`ifdef SEG_ERR_CNT_EN
   logic [7:0]  errCnt;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   int errSeen = 0;
   int frameSeen = 0;

   typedef struct packed {
      logic [7:0]  dig;
      logic [7:0]  seg;
      logic [7:0]  cycles;
      logic [31:0] expHex;
      logic [7:0]  expDp;
      logic [7:0]  expValid;
      logic [7:0]  expErr;
      logic [7:0]  expFrame;
   } vec_t;

   localparam int NUM_VECS = 22;
   vec_t vecs [NUM_VECS];

   seg_scan_decoder dut (
      .clk        (clk),
      .nRst       (nRst),
      .segIn      (segIn),
      .digIn      (digIn),
      .hexOut     (hexOut),
      .dpOut      (dpOut),
      .digValid   (digValid),
      .frameValid (frameValid),
      .errPulse   (errPulse)
`ifdef SEG_ERR_CNT_EN
      ,
      .errCnt     (errCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses are registered, so one sample per cycle on the falling edge counts each exactly once.
   always @(negedge clk) begin
      if (errPulse === 1'b1) errSeen++;
      if (frameValid === 1'b1) frameSeen++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive a pair for a number of rising edges, then settle on the following falling edge.
   task automatic applyStimulus(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
      digIn = dig;
      segIn = seg;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " hexOut"}, hexOut, 32'd0);
      checkOutput({tag, " dpOut"}, {24'd0, dpOut}, 32'd0);
      checkOutput({tag, " digValid"}, {24'd0, digValid}, 32'd0);
      checkOutput({tag, " frameValid"}, {31'd0, frameValid}, 32'd0);
      checkOutput({tag, " errPulse"}, {31'd0, errPulse}, 32'd0);
   endtask

   initial begin
      int errBefore;
      int frameBefore;
      logic [7:0] sel;

      vecs[0]  = '{8'hFE, 8'h06, 8'd5, 32'h00000001, 8'h00, 8'h01, 8'd0, 8'd0};
      vecs[1]  = '{8'hFE, 8'h3F, 8'd6, 32'h00000000, 8'h00, 8'h01, 8'd0, 8'd0};
      vecs[2]  = '{8'hFD, 8'h06, 8'd6, 32'h00000010, 8'h00, 8'h03, 8'd0, 8'd0};
      vecs[3]  = '{8'hFB, 8'h5B, 8'd6, 32'h00000210, 8'h00, 8'h07, 8'd0, 8'd0};
      vecs[4]  = '{8'hF7, 8'h4F, 8'd6, 32'h00003210, 8'h00, 8'h0F, 8'd0, 8'd0};
      vecs[5]  = '{8'hEF, 8'h66, 8'd6, 32'h00043210, 8'h00, 8'h1F, 8'd0, 8'd0};
      vecs[6]  = '{8'hDF, 8'h6D, 8'd6, 32'h00543210, 8'h00, 8'h3F, 8'd0, 8'd0};
      vecs[7]  = '{8'hBF, 8'h7D, 8'd6, 32'h06543210, 8'h00, 8'h7F, 8'd0, 8'd0};
      vecs[8]  = '{8'h7F, 8'h07, 8'd6, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd1};
      vecs[9]  = '{8'hFE, 8'h55, 8'd6, 32'h76543210, 8'h00, 8'h00, 8'd1, 8'd0};
      vecs[10] = '{8'hFF, 8'h00, 8'd4, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[11] = '{8'hFC, 8'h3F, 8'd6, 32'h76543210, 8'h00, 8'h00, 8'd1, 8'd0};
      vecs[12] = '{8'hFF, 8'h3F, 8'd3, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[13] = '{8'hFC, 8'h3F, 8'd3, 32'h76543210, 8'h00, 8'h00, 8'd1, 8'd0};
      vecs[14] = '{8'hFD, 8'h06, 8'd2, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[15] = '{8'hFD, 8'h5B, 8'd2, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[16] = '{8'hFD, 8'h06, 8'd2, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[17] = '{8'hFD, 8'h5B, 8'd2, 32'h76543210, 8'h00, 8'h00, 8'd0, 8'd0};
      vecs[18] = '{8'hFD, 8'hDB, 8'd5, 32'h76543220, 8'h02, 8'h02, 8'd0, 8'd0};
      vecs[19] = '{8'hFE, 8'h79, 8'd4, 32'h76543220, 8'h02, 8'h02, 8'd0, 8'd0};
      vecs[20] = '{8'hFE, 8'h79, 8'd1, 32'h7654322E, 8'h02, 8'h03, 8'd0, 8'd0};
      vecs[21] = '{8'hFE, 8'h79, 8'd3, 32'h7654322E, 8'h02, 8'h03, 8'd0, 8'd0};

      nRst  = 1'b1;
      digIn = 8'hFF;
      segIn = 8'h00;
      #2 nRst = 1'b0;
      #1;
      checkAllZero("reset");
`ifdef SEG_ERR_CNT_EN
      checkOutput("reset errCnt", {24'd0, errCnt}, 32'd0);
`endif
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      #1;

      for (int i = 0; i < NUM_VECS; i++) begin
         errBefore   = errSeen;
         frameBefore = frameSeen;
         applyStimulus(vecs[i].dig, vecs[i].seg, int'(vecs[i].cycles));
         checkOutput($sformatf("vec%0d hexOut", i), hexOut, vecs[i].expHex);
         checkOutput($sformatf("vec%0d dpOut", i), {24'd0, dpOut}, {24'd0, vecs[i].expDp});
         checkOutput($sformatf("vec%0d digValid", i), {24'd0, digValid}, {24'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d errPulses", i), 32'(errSeen - errBefore), {24'd0, vecs[i].expErr});
         checkOutput($sformatf("vec%0d framePulses", i), 32'(frameSeen - frameBefore), {24'd0, vecs[i].expFrame});
      end
`ifdef SEG_ERR_CNT_EN
      checkOutput("errCnt total", {24'd0, errCnt}, 32'd3);
`endif

      // Partial frame of six '8' digits, then reset discards it.
      frameBefore = frameSeen;
      for (int d = 0; d < 6; d++) begin
         sel = ~(8'h01 << d);
         applyStimulus(sel, 8'h7F, 6);
      end
      checkOutput("partial hexOut", hexOut, 32'h76888888);
      checkOutput("partial digValid", {24'd0, digValid}, 32'h0000003F);
      checkOutput("partial framePulses", 32'(frameSeen - frameBefore), 32'd0);
      nRst = 1'b0;
      #1;
      checkAllZero("midframe reset");
`ifdef SEG_ERR_CNT_EN
      checkOutput("midframe reset errCnt", {24'd0, errCnt}, 32'd0);
`endif
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      #1;

      // Full rescan with 'A' on every digit; the frame must wait for the eighth capture.
      frameBefore = frameSeen;
      for (int d = 0; d < 7; d++) begin
         sel = ~(8'h01 << d);
         applyStimulus(sel, 8'h77, 6);
      end
      checkOutput("rescan7 digValid", {24'd0, digValid}, 32'h0000007F);
      checkOutput("rescan7 framePulses", 32'(frameSeen - frameBefore), 32'd0);
      checkOutput("rescan7 hexOut", hexOut, 32'h0AAAAAAA);
      applyStimulus(8'h7F, 8'h77, 6);
      checkOutput("rescan8 hexOut", hexOut, 32'hAAAAAAAA);
      checkOutput("rescan8 digValid", {24'd0, digValid}, 32'd0);
      checkOutput("rescan8 framePulses", 32'(frameSeen - frameBefore), 32'd1);
      checkOutput("rescan8 dpOut", {24'd0, dpOut}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
